// File: rtl/alu_mul_sequencer.sv
`timescale 1ns/1ps
// alu_mul_sequencer
// Multi-cycle RV32M multiply controller (MUL/MULH/MULHSU/MULHU) for the EX
// stage. It owns no adder: every add/subtract is done on the shared 32-bit
// ALU through alu_a/alu_b/alu_ctrl, using alu_result and alu_c. The product
// is formed by a 32-step shift-and-add on sign-magnitude operands, with the
// 64-bit result negated afterwards when exactly one operand was negative.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid/ready  request handshake; accept on edge with valid & ready
//   req_op           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a, req_b     rs1 / rs2 operand values
//   kill             pipeline flush; aborts any in-flight operation
//   rsp_valid        one-cycle pulse qualifying rsp_data
//   rsp_data         low word (MUL) or high word (MULH*), held until next result
//   alu_a/b/ctrl     shared ALU operands and control (000 add, 001 sub)
//   alu_result/c     shared ALU result and carry-out
module alu_mul_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            kill,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_data,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_c
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic              carry_q, carry_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;

   logic              sa_in, sb_in;
   logic              neg;

   // MULH treats both operands as signed, MULHSU only rs1; MUL's low word is
   // sign-independent so it runs unsigned.
   assign sa_in = req_a[XLEN-1] & ((req_op == 2'b01) | (req_op == 2'b10));
   assign sb_in = req_b[XLEN-1] & (req_op == 2'b01);
   assign neg   = sa_q ^ sb_q;

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // through the case statement can leave it unassigned and infer a latch.
      state_d     = state_q;
      mcand_d     = mcand_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      carry_d     = carry_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      alu_a       = '0;
      alu_b       = '0;
      alu_ctrl    = ALU_ADD;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !kill) begin
               mcand_d = req_b;
               lo_d    = req_a;
               hi_d    = '0;
               cnt_d   = '0;
               op_d    = req_op;
               sa_d    = sa_in;
               sb_d    = sb_in;
               if (sa_in)      state_d = S_NEG_A;
               else if (sb_in) state_d = S_NEG_B;
               else            state_d = S_ITER;
            end
         end
         S_NEG_A: begin
            alu_ctrl = ALU_SUB;
            alu_b    = lo_q;
            lo_d     = alu_result;
            state_d  = sb_q ? S_NEG_B : S_ITER;
         end
         S_NEG_B: begin
            // 0x80000000 negates to itself, which is the unsigned magnitude 2^31.
            alu_ctrl = ALU_SUB;
            alu_b    = mcand_q;
            mcand_d  = alu_result;
            state_d  = S_ITER;
         end
         S_ITER: begin
            alu_a = hi_q;
            alu_b = lo_q[0] ? mcand_q : '0;
            // Partial sum plus carry shifts right one place into {hi, lo}.
            hi_d  = {alu_c, alu_result[XLEN-1:1]};
            lo_d  = {alu_result[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = neg ? S_FIX_LO : S_DONE;
         end
         S_FIX_LO: begin
            // Two's-complement of the 64-bit product: ~lo + 1, carry into hi.
            alu_a   = ~lo_q;
            alu_b   = {{(XLEN-1){1'b0}}, 1'b1};
            lo_d    = alu_result;
            carry_d = alu_c;
            state_d = S_FIX_HI;
         end
         S_FIX_HI: begin
            alu_a   = ~hi_q;
            alu_b   = {{(XLEN-1){1'b0}}, carry_q};
            hi_d    = alu_result;
            state_d = S_DONE;
         end
         S_DONE: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (op_q == 2'b00) ? lo_q : hi_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush wins over everything: back to idle, no response, data held.
      if (kill) begin
         state_d     = S_IDLE;
         rsp_valid_d = 1'b0;
         rsp_data_d  = rsp_data_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         carry_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
`timescale 1ns/1ps
module tb_alu_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        kill = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_ctrl;
   logic        alu_c;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_data = '0;

   always #5 clk = ~clk;

   // Shared ALU model: add with carry-out, or subtract.
   always_comb begin
      logic [32:0] sum;
      sum = {1'b0, alu_a} + {1'b0, alu_b};
      if (alu_ctrl == 3'b001) begin
         alu_result = alu_a - alu_b;
         alu_c      = 1'b0;
      end else begin
         alu_result = sum[31:0];
         alu_c      = sum[32];
      end
   end

   alu_mul_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .kill(kill),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_c(alu_c)
   );

   // Issue one request and follow it to its response.
   task automatic do_mul(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input int exp_lat);
      int lat;
      logic [2:0] exp_ctrl;
      bit signed_start;
      signed_start = (a[31] && (op == 2'b01 || op == 2'b10)) || (b[31] && op == 2'b01);
      exp_ctrl = signed_start ? 3'b001 : 3'b000;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || alu_ctrl !== exp_ctrl) begin
         errors++;
         $display("FAIL %s busy: ready=%b ctrl=%b want ready=0 ctrl=%b",
                  name, req_ready, alu_ctrl, exp_ctrl);
      end
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (rsp_valid === 1'b1) begin lat = i; break; end
      end
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (rsp_data !== exp_data || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s data: got %h ready=%b want %h ready=1",
                  name, rsp_data, req_ready, exp_data);
      end
      last_data = exp_data;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL %s single_pulse: rsp_valid=%b want 0", name, rsp_valid);
      end
   endtask

   // Watch n edges and flag any response pulse or data change.
   task automatic expect_quiet(input string name, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || rsp_data !== last_data) begin
         errors++;
         $display("FAIL %s quiet: pulse_seen=%b data=%h want no pulse, data %h",
                  name, seen, rsp_data, last_data);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || alu_a !== 32'h0 ||
          alu_b !== 32'h0 || alu_ctrl !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs: v=%b d=%h a=%h b=%h c=%b want all 0",
                  rsp_valid, rsp_data, alu_a, alu_b, alu_ctrl);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_unsigned();
      do_mul("mul_7x6",  2'b00, 32'd7,        32'd6,        32'd42,         33);
      do_mul("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33);
      do_mul("mul_ff",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   33);
   endtask

   task automatic test_signed();
      do_mul("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 35);
      do_mul("mulh_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
      do_mul("mulhsu_ff",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36);
      do_mul("mulh_m3x5",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 36);
      // sa=0, sb=1, neg=1: 33 + 0 + 1 + 2.
      do_mul("mulh_0xm1",  2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 36);
   endtask

   task automatic test_kill();
      // Kill in ITER with cnt=10.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd100; req_b = 32'd200;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1; kill = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL kill_iter: ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
      end
      expect_quiet("kill_iter", 40);
      do_mul("after_kill_3x3", 2'b00, 32'd3, 32'd3, 32'd9, 33);

      // kill with req_valid in IDLE: not accepted.
      @(negedge clk);
      kill = 1'b1; req_valid = 1'b1; req_a = 32'd5; req_b = 32'd5;
      @(posedge clk); #1;
      kill = 1'b0; req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL kill_idle_accept: ready=%b want 1", req_ready);
      end
      expect_quiet("kill_idle", 40);

      // Kill while in DONE: the pulse is suppressed and data held.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd11; req_b = 32'd13;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (32) @(posedge clk);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1; kill = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== last_data || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL kill_done: valid=%b data=%h ready=%b want 0 %h 1",
                  rsp_valid, rsp_data, req_ready, last_data);
      end
      expect_quiet("kill_done", 5);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b11; req_a = 32'hFFFFFFFF; req_b = 32'h12345678;
      @(posedge clk); #1; req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || alu_a !== 32'h0 ||
          alu_b !== 32'h0 || alu_ctrl !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: v=%b d=%h a=%h b=%h c=%b want all 0",
                  rsp_valid, rsp_data, alu_a, alu_b, alu_ctrl);
      end
      @(negedge clk); rst_n = 1'b1;
      last_data = 32'h0;
      expect_quiet("async_reset", 40);
   endtask

   task automatic test_back_to_back();
      do_mul("b2b_1", 2'b00, 32'd1000,     32'd1000, 32'd1000000,  33);
      do_mul("b2b_2", 2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 33);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_kill();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
